// File: rtl/countdown_timer_pkg.sv
// Shared types, limits and BCD helpers for the countdown timer.
package countdown_timer_pkg;

    localparam int unsigned DIGIT_W     = 4;
    localparam logic [3:0]  BCD_LIMIT_9 = 4'd9;
    localparam logic [3:0]  BCD_LIMIT_5 = 4'd5;
    localparam int unsigned BLINK_TICKS = 50;
    localparam int unsigned BLINK_W     = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    typedef struct packed {
        logic [DIGIT_W-1:0] minute_high;
        logic [DIGIT_W-1:0] minute_low;
        logic [DIGIT_W-1:0] second_high;
        logic [DIGIT_W-1:0] second_low;
        logic [DIGIT_W-1:0] msecond_high;
        logic [DIGIT_W-1:0] msecond_low;
    } digits_t;

    // Saturate a preset digit to the largest legal value for its position.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    // One 10 ms step down with borrow through every digit.
    function automatic digits_t bcd_decrement(input digits_t d);
        digits_t r;
        r = d;
        if (d.msecond_low != 4'd0) begin
            r.msecond_low = d.msecond_low - 4'd1;
        end else begin
            r.msecond_low = BCD_LIMIT_9;
            if (d.msecond_high != 4'd0) begin
                r.msecond_high = d.msecond_high - 4'd1;
            end else begin
                r.msecond_high = BCD_LIMIT_9;
                if (d.second_low != 4'd0) begin
                    r.second_low = d.second_low - 4'd1;
                end else begin
                    r.second_low = BCD_LIMIT_9;
                    if (d.second_high != 4'd0) begin
                        r.second_high = d.second_high - 4'd1;
                    end else begin
                        r.second_high = BCD_LIMIT_5;
                        if (d.minute_low != 4'd0) begin
                            r.minute_low = d.minute_low - 4'd1;
                        end else begin
                            r.minute_low  = BCD_LIMIT_9;
                            r.minute_high = d.minute_high - 4'd1;
                        end
                    end
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Keys, presets and display/status outputs of the countdown timer.
interface countdown_timer_if;
    logic       key_load;
    logic       key_start_pause;
    logic [3:0] preset_minute_high;
    logic [3:0] preset_minute_low;
    logic [3:0] preset_second_high;
    logic [3:0] preset_second_low;
    logic [3:0] minute_high;
    logic [3:0] minute_low;
    logic [3:0] second_high;
    logic [3:0] second_low;
    logic [3:0] msecond_high;
    logic [3:0] msecond_low;
    logic       running;
    logic       alarm;

    modport master (
        output key_load, key_start_pause,
        output preset_minute_high, preset_minute_low, preset_second_high, preset_second_low,
        input  minute_high, minute_low, second_high, second_low, msecond_high, msecond_low,
        input  running, alarm
    );

    modport slave (
        input  key_load, key_start_pause,
        input  preset_minute_high, preset_minute_low, preset_second_high, preset_second_low,
        output minute_high, minute_low, second_high, second_low, msecond_high, msecond_low,
        output running, alarm
    );
endinterface

// File: rtl/countdown_timer_key_debounce.sv
// Active-low pushbutton debouncer: one pulse per press held DELAY_TIME cycles.
module key_debounce #(
    parameter int unsigned DELAY_TIME = 10000000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press_pulse
);
    localparam int unsigned    CNT_W   = 32;
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(DELAY_TIME - 1);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(DELAY_TIME + 1);

    logic [CNT_W-1:0] cnt;

    // Low-time counter; saturation stops it ever revisiting the fire value.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (key_n) begin
            cnt <= '0;
        end else if (cnt != CNT_SAT) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Pulse is high exactly while the counter holds DELAY_TIME.
    always_ff @(posedge clk) begin
        if (reset) begin
            press_pulse <= 1'b0;
        end else begin
            press_pulse <= !key_n && (cnt == CNT_PRE);
        end
    end
endmodule

// File: rtl/countdown_timer.sv
// mm:ss.cc countdown timer with debounced keys and expiry alarm.
// Optional: define COUNTDOWN_ALARM_BLINK_EN to blink the alarm at 0.5 s in EXPIRED.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int unsigned CONST_50M  = 500000,
    parameter int unsigned DELAY_TIME = 10000000
) (
    input  logic               clk,
    input  logic               reset,
    countdown_timer_if.slave   bus
);
    localparam int unsigned        PRESC_W    = (CONST_50M > 1) ? $clog2(CONST_50M) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CONST_50M - 1);

    state_t             state;
    digits_t            digits;
    digits_t            preset_clamped;
    digits_t            digits_dec;
    logic [PRESC_W-1:0] presc;
    logic               running;
    logic               alarm;
    logic               load_ev;
    logic               sp_ev;
    logic               presc_tick;
`ifdef COUNTDOWN_ALARM_BLINK_EN
    logic [BLINK_W-1:0] blink_cnt;
`endif

    key_debounce #(.DELAY_TIME(DELAY_TIME)) u_deb_load (
        .clk         (clk),
        .reset       (reset),
        .key_n       (bus.key_load),
        .press_pulse (load_ev)
    );

    key_debounce #(.DELAY_TIME(DELAY_TIME)) u_deb_start (
        .clk         (clk),
        .reset       (reset),
        .key_n       (bus.key_start_pause),
        .press_pulse (sp_ev)
    );

    // Clamped preset and next-lower count.
    always_comb begin
        preset_clamped              = '0;
        preset_clamped.minute_high  = clamp_digit(bus.preset_minute_high, BCD_LIMIT_9);
        preset_clamped.minute_low   = clamp_digit(bus.preset_minute_low,  BCD_LIMIT_9);
        preset_clamped.second_high  = clamp_digit(bus.preset_second_high, BCD_LIMIT_5);
        preset_clamped.second_low   = clamp_digit(bus.preset_second_low,  BCD_LIMIT_9);
        digits_dec                  = bcd_decrement(digits);
        presc_tick                  = (presc == PRESC_LAST);
    end

    // Timer FSM: load beats start/pause, key events beat the prescaler.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            digits  <= '0;
            presc   <= '0;
            running <= 1'b0;
            alarm   <= 1'b0;
`ifdef COUNTDOWN_ALARM_BLINK_EN
            blink_cnt <= '0;
`endif
        end else if (load_ev) begin
            state   <= ST_IDLE;
            digits  <= preset_clamped;
            presc   <= '0;
            running <= 1'b0;
            alarm   <= 1'b0;
        end else if (sp_ev) begin
            case (state)
                ST_IDLE: begin
                    if (digits != '0) begin
                        state   <= ST_RUNNING;
                        presc   <= '0;
                        running <= 1'b1;
                    end
                end
                ST_RUNNING: begin
                    state   <= ST_PAUSED;
                    running <= 1'b0;
                end
                ST_PAUSED: begin
                    state   <= ST_RUNNING;
                    running <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                    alarm <= 1'b0;
                    presc <= '0;
                end
            endcase
        end else begin
            case (state)
                ST_RUNNING: begin
                    if (presc_tick) begin
                        presc <= '0;
                        if (digits != '0) begin
                            digits <= digits_dec;
                            if (digits_dec == '0) begin
                                state   <= ST_EXPIRED;
                                running <= 1'b0;
                                alarm   <= 1'b1;
`ifdef COUNTDOWN_ALARM_BLINK_EN
                                blink_cnt <= '0;
`endif
                            end
                        end
                    end else begin
                        presc <= presc + PRESC_W'(1);
                    end
                end
`ifdef COUNTDOWN_ALARM_BLINK_EN
                ST_EXPIRED: begin
                    if (presc_tick) begin
                        presc <= '0;
                        if (blink_cnt == BLINK_W'(BLINK_TICKS - 1)) begin
                            blink_cnt <= '0;
                            alarm     <= !alarm;
                        end else begin
                            blink_cnt <= blink_cnt + BLINK_W'(1);
                        end
                    end else begin
                        presc <= presc + PRESC_W'(1);
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.minute_high  = digits.minute_high;
    assign bus.minute_low   = digits.minute_low;
    assign bus.second_high  = digits.second_high;
    assign bus.second_low   = digits.second_low;
    assign bus.msecond_high = digits.msecond_high;
    assign bus.msecond_low  = digits.msecond_low;
    assign bus.running      = running;
    assign bus.alarm        = alarm;
endmodule
